clk_ratio_monitor: RTL and testbench

Edge-counting monitor that sits directly downstream of the divide-by-2.5 clock generator. It samples the divided output in the source clock domain and counts its rising edges over a fixed window of source-clock cycles. At the end of each window it reports the count and a pass/fail verdict against an expected range. A sticky error flag lets the system catch a stalled or mis-ratioed divider without polling every window.

---
 rtl/clk_ratio_monitor.sv | 126 ++++++++++++
 tb/tb_clk_ratio_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_monitor.sv
// Counts rising edges of a divided clock over fixed windows of clk and reports
// each window's count with a pass/fail verdict plus a sticky error flag.
module clk_ratio_monitor #(
  parameter int WINDOW  = 100,
  parameter int EXP_MIN = 39,
  parameter int EXP_MAX = 41,
  parameter int SETTLE  = 4,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mon_in,
  input  logic          err_clr,
  output logic [CW-1:0] edge_cnt,
  output logic          meas_valid,
  output logic          meas_pass,
  output logic          err_sticky
);

  // state      | meaning
  // ST_IDLE    | disabled, counters held at 0
  // ST_SETTLE  | synchroniser/edge-detect flush after enable, rises ignored
  // ST_MEASURE | counting rises over back-to-back windows
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam int WW = $clog2(WINDOW);
  localparam int SW = $clog2(SETTLE);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [CW-1:0] ACC_MAX  = '1;
  localparam logic [31:0]   LIM_LO   = 32'(EXP_MIN);
  localparam logic [31:0]   LIM_HI   = 32'(EXP_MAX);

  logic          s1, s2, s3;
  logic          rise;
  logic [1:0]    state;
  logic [SW-1:0] set_cnt;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_next;
  logic          win_close;
  logic          win_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise      = s2 & ~s3;
  // Saturating accumulate; also the reported value when the window closes.
  assign acc_next  = (rise && (acc != ACC_MAX)) ? acc + CW'(1) : acc;
  assign win_close = en && (state == ST_MEASURE) && (win_cnt == WIN_LAST);
  assign win_pass  = (32'(acc_next) >= LIM_LO) && (32'(acc_next) <= LIM_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      set_cnt    <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      edge_cnt   <= '0;
      meas_valid <= 1'b0;
      meas_pass  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        set_cnt <= '0;
        win_cnt <= '0;
        acc     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SETTLE;
            set_cnt <= '0;
          end
          ST_SETTLE: begin
            if (set_cnt == SET_LAST) begin
              state   <= ST_MEASURE;
              set_cnt <= '0;
              win_cnt <= '0;
              acc     <= '0;
            end else begin
              set_cnt <= set_cnt + SW'(1);
            end
          end
          ST_MEASURE: begin
            if (win_close) begin
              win_cnt    <= '0;
              acc        <= '0;
              edge_cnt   <= acc_next;
              meas_pass  <= win_pass;
              meas_valid <= 1'b1;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              acc     <= acc_next;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // A failing result outranks a simultaneous clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (win_close && !win_pass) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: default instance plus a CW=4 instance
// sharing stimulus, checked against a window edge-count reference model.
module tb_clk_ratio_monitor;
  localparam int WINDOW  = 100;
  localparam int EXP_MIN = 39;
  localparam int EXP_MAX = 41;
  localparam int SETTLE  = 4;
  localparam int HN      = 8192;

  typedef struct {
    int e;
    int cnt;
    bit pass;
    bit err;
  } exp_t;

  typedef enum int {M_STALL, M_DIV, M_TOGGLE, M_RAND} mode_t;

  logic clk = 1'b0;
  logic rst, en, mon_in, err_clr;
  logic [7:0] edge_cnt;
  logic       meas_valid, meas_pass, err_sticky;
  logic [3:0] edge_cnt4;
  logic       meas_valid4, meas_pass4, err_sticky4;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    hist[HN];
  exp_t  q0[$];
  exp_t  q1[$];
  int    en_start   = -1;
  int    next_close = -1;
  bit    m_err[2];
  int    n_push0 = 0;
  int    n_pop0  = 0;
  int    last_valid_e = -1;
  int    prev_valid_e = -1;
  mode_t mode = M_DIV;
  int    ph   = 0;
  logic [4:0] div_pat = 5'b01101;  // 1,0,1,1,0: two rises per five clk cycles

  clk_ratio_monitor dut (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_in), .err_clr(err_clr),
    .edge_cnt(edge_cnt), .meas_valid(meas_valid), .meas_pass(meas_pass),
    .err_sticky(err_sticky)
  );

  clk_ratio_monitor #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_in), .err_clr(err_clr),
    .edge_cnt(edge_cnt4), .meas_valid(meas_valid4), .meas_pass(meas_pass4),
    .err_sticky(err_sticky4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
    end
  endtask

  // Rising edges seen by the monitor in the window closing at edge e: a rise is
  // visible in the cycle after edge j when samples j-2, j-1 read 0, 1.
  function automatic int win_count(input int e, input int maxv);
    int c = 0;
    for (int j = e - WINDOW; j < e; j++)
      if (j >= 2 && j < HN)
        if (hist[j-1] && !hist[j-2]) c++;
    return (c > maxv) ? maxv : c;
  endfunction

  always @(posedge clk) begin : model
    bit   closing;
    exp_t it;
    if (cyc < HN) hist[cyc] = rst ? 1'b0 : mon_in;
    closing = 1'b0;
    if (rst) begin
      en_start   = -1;
      next_close = -1;
      m_err[0]   = 1'b0;
      m_err[1]   = 1'b0;
    end else begin
      if (!en) begin
        en_start   = -1;
        next_close = -1;
      end else if (en_start < 0) begin
        en_start   = cyc;
        next_close = cyc + SETTLE + WINDOW;
      end else if (cyc == next_close) begin
        closing    = 1'b1;
        next_close = next_close + WINDOW;
      end
      for (int k = 0; k < 2; k++) begin
        if (closing) begin
          it.e    = cyc;
          it.cnt  = win_count(cyc, (k == 0) ? 255 : 15);
          it.pass = (it.cnt >= EXP_MIN) && (it.cnt <= EXP_MAX);
          if (!it.pass) m_err[k] = 1'b1;
          else if (err_clr) m_err[k] = 1'b0;
          it.err = m_err[k];
          if (k == 0) begin
            q0.push_back(it);
            n_push0++;
          end else begin
            q1.push_back(it);
          end
        end else if (err_clr) begin
          m_err[k] = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic scoreboard(input int k, input logic v, input int cnt,
                            input logic pass, input logic err);
    exp_t it;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      it = (k == 0) ? q0[0] : q1[0];
      if (it.e < cyc - 1) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb%0d_missing: meas_valid 0, expected pulse after edge %0d", k, it.e);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        sz--;
      end
    end
    if (v) begin
      if (sz == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb%0d_unexpected: meas_valid 1 after edge %0d, expected 0", k, cyc - 1);
      end else begin
        if (k == 0) begin
          it = q0.pop_front();
          n_pop0++;
          prev_valid_e = last_valid_e;
          last_valid_e = cyc - 1;
        end else begin
          it = q1.pop_front();
        end
        chk($sformatf("sb%0d_time", k), cyc - 1, it.e);
        chk($sformatf("sb%0d_edge_cnt", k), cnt, it.cnt);
        chk($sformatf("sb%0d_meas_pass", k), int'(pass), int'(it.pass));
        chk($sformatf("sb%0d_err_sticky", k), int'(err), int'(it.err));
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    scoreboard(0, meas_valid, int'(edge_cnt), meas_pass, err_sticky);
    scoreboard(1, meas_valid4, int'(edge_cnt4), meas_pass4, err_sticky4);
  end

  task automatic tick(input bit clr = 1'b0);
    @(negedge clk);
    case (mode)
      M_STALL:  mon_in = 1'b0;
      M_DIV:    mon_in = div_pat[ph % 5];
      M_TOGGLE: mon_in = ph[0];
      default:  mon_in = 1'($urandom_range(1, 0));
    endcase
    ph++;
    err_clr = clr;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_meas_pass"}, int'(meas_pass), 0);
    chk({tag, "_err_sticky"}, int'(err_sticky), 0);
    chk({tag, "_edge_cnt4"}, int'(edge_cnt4), 0);
    chk({tag, "_err_sticky4"}, int'(err_sticky4), 0);
  endtask

  initial begin
    int reen;
    int found;
    rst = 1'b1; en = 1'b0; mon_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_outputs_zero("reset");

    // Nominal divider: 40 edges per window, 100-cycle cadence.
    tick(); rst = 1'b0; en = 1'b1;
    run(SETTLE + 3*WINDOW + 5);
    chk("div_edge_cnt", int'(edge_cnt), 40);
    chk("div_pass", int'(meas_pass), 1);
    chk("div_err", int'(err_sticky), 0);
    chk("div_period", last_valid_e - prev_valid_e, WINDOW);
    chk("cw4_sat_cnt", int'(edge_cnt4), 15);
    chk("cw4_pass", int'(meas_pass4), 0);
    chk("cw4_err", int'(err_sticky4), 1);

    // Stalled divider, recovery keeps the sticky flag, then clear.
    mode = M_STALL;
    run(2*WINDOW + 3);
    chk("stall_edge_cnt", int'(edge_cnt), 0);
    chk("stall_pass", int'(meas_pass), 0);
    chk("stall_err", int'(err_sticky), 1);
    mode = M_DIV;
    run(2*WINDOW + 3);
    chk("recover_edge_cnt", int'(edge_cnt), 40);
    chk("recover_err_held", int'(err_sticky), 1);
    tick(1'b1); tick(); tick();
    chk("err_clr_drops", int'(err_sticky), 0);

    // clk/2 input with err_clr colliding with each window close.
    mode = M_TOGGLE;
    run(3);
    for (int i = 0; i < 2*WINDOW; i++) begin
      tick();
      if (cyc == next_close) err_clr = 1'b1;
    end
    tick(); tick();
    chk("toggle_edge_cnt", int'(edge_cnt), 50);
    chk("toggle_pass", int'(meas_pass), 0);
    chk("set_wins_err", int'(err_sticky), 1);

    // Abort a window at win_cnt=60, re-enable 10 cycles later.
    mode = M_DIV;
    found = 0;
    for (int i = 0; i < 3*WINDOW; i++) begin
      tick();
      if (next_close >= 0 && cyc == next_close - 39) begin
        found = 1;
        break;
      end
    end
    chk("abort_point_found", found, 1);
    en = 1'b0;
    run(10);
    en = 1'b1;
    reen = cyc;
    run(SETTLE + WINDOW + 3);
    chk("reen_latency", last_valid_e, reen + SETTLE + WINDOW);
    chk("reen_edge_cnt", int'(edge_cnt), 40);
    chk("reen_pass", int'(meas_pass), 1);

    // Reset in mid-window after a failing clk/2 result.
    mode = M_TOGGLE;
    run(2*WINDOW + 3);
    chk("pre_rst_edge_cnt", int'(edge_cnt), 50);
    chk("pre_rst_err", int'(err_sticky), 1);
    run(30);
    rst = 1'b1;
    #1 chk_outputs_zero("mid_rst");
    mode = M_DIV;
    run(3);
    rst = 1'b0;
    reen = cyc;
    run(SETTLE + WINDOW + 3);
    chk("post_rst_latency", last_valid_e, reen + SETTLE + WINDOW);
    chk("post_rst_edge_cnt", int'(edge_cnt), 40);
    chk("post_rst_pass", int'(meas_pass), 1);

    // Random input bits, random clears and enable drops.
    mode = M_RAND;
    for (int i = 0; i < 4*WINDOW; i++) begin
      tick(($urandom % 16) == 0);
      if (en && ($urandom % 150) == 0) en = 1'b0;
      else if (!en && ($urandom % 8) == 0) en = 1'b1;
    end
    mode = M_DIV;
    en = 1'b1;
    run(SETTLE + 2*WINDOW + 5);
    chk("final_edge_cnt", int'(edge_cnt), 40);
    chk("final_pass", int'(meas_pass), 1);
    en = 1'b0;
    run(5);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("valid_count", n_pop0, n_push0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
